// File: rtl/ctrl_system.sv
// ---------------------------------------------------------------------------
// ctrl_system
//
// Six-axis stepper-motor controller with a five-button, four-digit LCD user
// interface.
//
// After reset every motor is driven toward home until its limit switch trips.
// Once all motors are homed, the block enters RUN. In RUN the user:
//   - selects a motor (0-5);
//   - dials a three-digit decimal target (000-999 steps);
//   - commits the target with E.
// Each motor then steps independently until its position equals its target.
//
// Ports
//   sysclk      system clock, rising edge
//   rst_n       asynchronous active-low reset
//   Stop[5:0]   limit/home switch per motor, active high, asynchronous
//   L, R        cursor left / right buttons, active high, asynchronous
//   U, D        increment / decrement the field under the cursor
//   E           commit the dialled target to the selected motor
//   Num[1:0]    cursor position: 0 = motor select, 1 = hundreds,
//               2 = tens, 3 = units
//   LCD_Enable  high once homing has finished (display valid)
//   LCD_Num     value shown for the field at the cursor (0-9)
//   PU[5:0]     step pulse per motor
//   MF[5:0]     driver enable per motor, high = energised
//   DR[5:0]     direction per motor, 1 = away from home, 0 = toward home
// ---------------------------------------------------------------------------
module ctrl_system #(
  parameter int STEP_HALF = 100,
  parameter int NMOT      = 6
) (
  input  logic            sysclk,
  input  logic            rst_n,
  input  logic [NMOT-1:0] Stop,
  input  logic            L,
  input  logic            R,
  input  logic            U,
  input  logic            D,
  input  logic            E,
  output logic [1:0]      Num,
  output logic            LCD_Enable,
  output logic [3:0]      LCD_Num,
  output logic [NMOT-1:0] PU,
  output logic [NMOT-1:0] MF,
  output logic [NMOT-1:0] DR
);

  localparam int CW = (STEP_HALF > 1) ? $clog2(STEP_HALF) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(STEP_HALF - 1);
  localparam logic [2:0]    SEL_MAX   = 3'(NMOT - 1);

  // Bit positions of the buttons inside the conditioned button vector.
  localparam int BD = 0;
  localparam int BU = 1;
  localparam int BR = 2;
  localparam int BL = 3;
  localparam int BE = 4;

  typedef enum logic {
    ST_HOMING,
    ST_RUN
  } state_t;

  state_t state, state_next;

  logic [4:0]      btn_meta, btn_sync, btn_prev, btn_rise;
  logic [NMOT-1:0] stop_meta, stop_sync;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic [NMOT-1:0] homed;

  logic       act_e, act_l, act_r, act_u, act_d;
  logic [2:0] sel;
  logic [3:0] dig_h, dig_t, dig_u;
  logic [9:0] commit_val;

  logic [9:0] pos    [NMOT];
  logic [9:0] target [NMOT];

  // Wrapping helpers for the BCD digits and the motor selector.
  function automatic logic [3:0] bcd_inc(input logic [3:0] v);
    return (v >= 4'd9) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] v);
    return (v == 4'd0 || v > 4'd9) ? 4'd9 : v - 4'd1;
  endfunction

  function automatic logic [2:0] sel_inc(input logic [2:0] v);
    return (v >= SEL_MAX) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic logic [2:0] sel_dec(input logic [2:0] v);
    return (v == 3'd0 || v > SEL_MAX) ? SEL_MAX : v - 3'd1;
  endfunction

  // Two-flop synchronisers for every asynchronous input.
  // The extra btn_prev stage turns each button into a single-cycle
  // rising-edge event, so holding a button never repeats its action.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta  <= '0;
      btn_sync  <= '0;
      btn_prev  <= '0;
      stop_meta <= '0;
      stop_sync <= '0;
    end else begin
      btn_meta  <= {E, L, R, U, D};
      btn_sync  <= btn_meta;
      btn_prev  <= btn_sync;
      stop_meta <= Stop;
      stop_sync <= stop_meta;
    end
  end

  assign btn_rise = btn_sync & ~btn_prev;

  // Shared free-running step timebase.
  // All motors toggle PU on the same tick, so every pulse is exactly
  // STEP_HALF cycles high and STEP_HALF cycles low.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Top-level state register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HOMING;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // Homing ends only when every motor has reported its home switch.
  // The display is valid from then on.
  always_comb begin
    state_next = state;
    LCD_Enable = 1'b0;
    case (state)
      ST_HOMING: begin
        if (&homed) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        LCD_Enable = 1'b1;
      end
      default: begin
        state_next = ST_HOMING;
      end
    endcase
  end

  // Button arbitration.
  // When several edges land in the same cycle, exactly one action is
  // granted, in the order E, L, R, U, D. Buttons are ignored while homing.
  always_comb begin
    act_e = 1'b0;
    act_l = 1'b0;
    act_r = 1'b0;
    act_u = 1'b0;
    act_d = 1'b0;
    if (state == ST_RUN) begin
      if (btn_rise[BE]) begin
        act_e = 1'b1;
      end else if (btn_rise[BL]) begin
        act_l = 1'b1;
      end else if (btn_rise[BR]) begin
        act_r = 1'b1;
      end else if (btn_rise[BU]) begin
        act_u = 1'b1;
      end else if (btn_rise[BD]) begin
        act_d = 1'b1;
      end
    end
  end

  // Cursor, motor selector and edit-buffer digits.
  // The digits are deliberately kept after a commit, so the same value can
  // be sent to several motors without retyping it.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      Num   <= 2'd0;
      sel   <= 3'd0;
      dig_h <= 4'd0;
      dig_t <= 4'd0;
      dig_u <= 4'd0;
    end else if (act_l) begin
      Num <= Num - 2'd1;
    end else if (act_r) begin
      Num <= Num + 2'd1;
    end else if (act_u) begin
      case (Num)
        2'd0:    sel   <= sel_inc(sel);
        2'd1:    dig_h <= bcd_inc(dig_h);
        2'd2:    dig_t <= bcd_inc(dig_t);
        default: dig_u <= bcd_inc(dig_u);
      endcase
    end else if (act_d) begin
      case (Num)
        2'd0:    sel   <= sel_dec(sel);
        2'd1:    dig_h <= bcd_dec(dig_h);
        2'd2:    dig_t <= bcd_dec(dig_t);
        default: dig_u <= bcd_dec(dig_u);
      endcase
    end
  end

  // Display value: follows the registers combinationally.
  always_comb begin
    case (Num)
      2'd0:    LCD_Num = {1'b0, sel};
      2'd1:    LCD_Num = dig_h;
      2'd2:    LCD_Num = dig_t;
      default: LCD_Num = dig_u;
    endcase
  end

  assign commit_val = 10'(dig_h) * 10'd100 + 10'(dig_t) * 10'd10 + 10'(dig_u);

  // Per-motor targets.
  // The home-switch safety clear comes after the commit, so a switch hit
  // on a homeward move always wins over a commit in the same cycle.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NMOT; i++) begin
        target[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NMOT; i++) begin
        if (act_e && sel == 3'(i)) begin
          target[i] <= commit_val;
        end
        if (state == ST_RUN && stop_sync[i] && !DR[i]) begin
          target[i] <= '0;
        end
      end
    end
  end

  // Per-motor step engine.
  //
  // Homing: drive toward home until the switch is seen. Position is not
  // tracked while homing, because it is unknown until the switch trips.
  //
  // RUN: a step starts on a tick while PU is low and ends on the next tick.
  // The position moves on the falling edge of PU. Direction and enable are
  // only re-evaluated while PU is low, so a retarget takes effect at the
  // next step boundary. Targets are limited to 0-999 by the BCD edit
  // buffer, and the motor only steps toward its target, so the position
  // never leaves that range.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      PU    <= '0;
      MF    <= '0;
      DR    <= '0;
      homed <= '0;
      for (int i = 0; i < NMOT; i++) begin
        pos[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NMOT; i++) begin
        if (state == ST_HOMING) begin
          DR[i]  <= 1'b0;
          pos[i] <= '0;
          if (homed[i] || stop_sync[i]) begin
            PU[i]    <= 1'b0;
            MF[i]    <= 1'b0;
            homed[i] <= 1'b1;
          end else begin
            MF[i] <= 1'b1;
            if (tick) begin
              PU[i] <= ~PU[i];
            end
          end
        end else if (stop_sync[i] && !DR[i]) begin
          PU[i]  <= 1'b0;
          MF[i]  <= 1'b0;
          pos[i] <= '0;
        end else if (PU[i]) begin
          if (tick) begin
            PU[i]  <= 1'b0;
            pos[i] <= DR[i] ? pos[i] + 10'd1 : pos[i] - 10'd1;
          end
        end else begin
          DR[i] <= (target[i] > pos[i]);
          MF[i] <= (target[i] != pos[i]);
          if (tick && target[i] != pos[i]) begin
            PU[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_system.sv
// ---------------------------------------------------------------------------
// tb_ctrl_system
//
// Directed, self-checking bench for ctrl_system.
//
// A pulse monitor counts the PU rising edges of every motor. It also
// records any pulse whose high time or period differs from the expected
// step timing. The scenario tasks compare outputs and monitor counts
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ctrl_system;

  localparam int SH = 10;

  localparam logic [4:0] B_D = 5'b00001;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_R = 5'b00100;
  localparam logic [4:0] B_L = 5'b01000;
  localparam logic [4:0] B_E = 5'b10000;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [5:0] stop   = '0;
  logic [4:0] btn    = '0;
  logic [1:0] num;
  logic       lcd_enable;
  logic [3:0] lcd_num;
  logic [5:0] pu, mf, dr;

  int n_cmp = 0;
  int n_bad = 0;

  int         rise_cnt   [6] = '{default: 0};
  int         since_rise [6] = '{default: 0};
  int         hi_run     [6] = '{default: 0};
  int         period_err [6] = '{default: 0};
  int         width_err  [6] = '{default: 0};
  bit         mf_run     [6] = '{default: 0};
  logic [5:0] pu_q = '0;

  always #5 sysclk = ~sysclk;

  ctrl_system #(.STEP_HALF(SH), .NMOT(6)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .Stop      (stop),
    .L         (btn[3]),
    .R         (btn[2]),
    .U         (btn[1]),
    .D         (btn[0]),
    .E         (btn[4]),
    .Num       (num),
    .LCD_Enable(lcd_enable),
    .LCD_Num   (lcd_num),
    .PU        (pu),
    .MF        (mf),
    .DR        (dr)
  );

  // Pulse monitor, sampled 1 time unit after each rising clock edge.
  // The period is only checked between rises within one continuous
  // enabled run.
  always @(posedge sysclk) begin
    #1;
    for (int i = 0; i < 6; i++) begin
      since_rise[i]++;
      if (pu[i] && !pu_q[i]) begin
        rise_cnt[i]++;
        if (mf_run[i] && since_rise[i] != 2 * SH) period_err[i]++;
        since_rise[i] = 0;
        hi_run[i]     = 1;
        mf_run[i]     = 1'b1;
      end else if (pu[i]) begin
        hi_run[i]++;
      end else if (pu_q[i] && hi_run[i] != SH) begin
        width_err[i]++;
      end
      if (!mf[i]) mf_run[i] = 1'b0;
      pu_q[i] = pu[i];
    end
  end

  // Press a button combination: hold it 4 cycles, then release it 4 cycles.
  task automatic press(input logic [4:0] mask);
    btn = mask;
    repeat (4) @(negedge sysclk);
    btn = '0;
    repeat (4) @(negedge sysclk);
  endtask

  // Wait until motor m is idle (MF and PU low), within a cycle budget.
  task automatic wait_idle(input int m, input int budget, output bit ok);
    int c;
    ok = 1'b0;
    c  = 0;
    while (!ok && c < budget) begin
      @(negedge sysclk);
      if (!mf[m] && !pu[m]) ok = 1'b1;
      c++;
    end
  endtask

  // Wait until motor m has produced at least `count` pulses in total.
  task automatic wait_rises(input int m, input int count, input int budget, output bit ok);
    int c;
    ok = 1'b0;
    c  = 0;
    while (!ok && c < budget) begin
      @(negedge sysclk);
      if (rise_cnt[m] >= count) ok = 1'b1;
      c++;
    end
  endtask

  task automatic test_reset;
    logic [5:0] stepping;
    rst_n = 1'b0;
    repeat (3) @(negedge sysclk);
    n_cmp++;
    if ({pu, mf, dr} !== 18'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_drivers: pu/mf/dr=%h required 0", {pu, mf, dr});
    end
    n_cmp++;
    if ({lcd_enable, num, lcd_num} !== 7'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_ui: en/num/lcd=%h required 0", {lcd_enable, num, lcd_num});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);
    n_cmp++;
    if (mf !== 6'h3F) begin
      n_bad++;
      $display("[TB] FAIL homing_enable: mf=%b required 111111", mf);
    end
    repeat (4 * SH) @(negedge sysclk);
    for (int i = 0; i < 6; i++) stepping[i] = (rise_cnt[i] > 0);
    n_cmp++;
    if (stepping !== 6'h3F) begin
      n_bad++;
      $display("[TB] FAIL homing_stepping: stepping=%b required 111111", stepping);
    end
  endtask

  task automatic test_homing;
    logic [5:0] exp_mf;
    int         snap;
    for (int i = 0; i < 6; i++) begin
      stop[i] = 1'b1;
      repeat (4) @(negedge sysclk);
      for (int j = 0; j < 6; j++) exp_mf[j] = (j > i);
      n_cmp++;
      if (mf !== exp_mf || pu[i] !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL homing_halt_%0d: mf=%b pu=%b required mf=%b pu[%0d]=0", i, mf, pu, exp_mf, i);
      end
      n_cmp++;
      if (dr !== 6'd0) begin
        n_bad++;
        $display("[TB] FAIL homing_dir_%0d: dr=%b required 000000", i, dr);
      end
      snap = rise_cnt[i];
      repeat (2 * SH + 2) @(negedge sysclk);
      n_cmp++;
      if (rise_cnt[i] !== snap) begin
        n_bad++;
        $display("[TB] FAIL homing_still_%0d: pulses=%0d required %0d", i, rise_cnt[i], snap);
      end
      n_cmp++;
      if (lcd_enable !== (i == 5)) begin
        n_bad++;
        $display("[TB] FAIL lcd_enable_%0d: lcd_enable=%b required %b", i, lcd_enable, i == 5);
      end
    end
    stop = '0;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic test_select_wrap;
    n_cmp++;
    if (num !== 2'd0 || lcd_num !== 4'd0) begin
      n_bad++;
      $display("[TB] FAIL run_start: num=%0d lcd=%0d required 0/0", num, lcd_num);
    end
    press(B_U);
    n_cmp++;
    if (lcd_num !== 4'd1) begin
      n_bad++;
      $display("[TB] FAIL sel_up: lcd=%0d required 1", lcd_num);
    end
    press(B_D);
    n_cmp++;
    if (lcd_num !== 4'd0) begin
      n_bad++;
      $display("[TB] FAIL sel_down: lcd=%0d required 0", lcd_num);
    end
    press(B_D);
    n_cmp++;
    if (lcd_num !== 4'd5) begin
      n_bad++;
      $display("[TB] FAIL sel_wrap: lcd=%0d required 5", lcd_num);
    end
  endtask

  task automatic test_forward_move;
    int snap, werr, perr;
    bit ok;
    press(B_R);
    press(B_R);
    press(B_R);
    n_cmp++;
    if (num !== 2'd3) begin
      n_bad++;
      $display("[TB] FAIL cursor_right: num=%0d required 3", num);
    end
    press(B_U);
    press(B_L);
    press(B_U);
    n_cmp++;
    if (num !== 2'd2 || lcd_num !== 4'd1) begin
      n_bad++;
      $display("[TB] FAIL tens_up: num=%0d lcd=%0d required 2/1", num, lcd_num);
    end
    snap = rise_cnt[5];
    werr = width_err[5];
    perr = period_err[5];
    press(B_E);
    n_cmp++;
    if (dr[5] !== 1'b1 || mf !== 6'b100000) begin
      n_bad++;
      $display("[TB] FAIL fwd_start: dr=%b mf=%b required dr[5]=1 mf=100000", dr, mf);
    end
    wait_idle(5, 1000, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("[TB] FAIL fwd_timeout: mf=%b required idle", mf);
    end
    n_cmp++;
    if (rise_cnt[5] - snap !== 11) begin
      n_bad++;
      $display("[TB] FAIL fwd_pulses: pulses=%0d required 11", rise_cnt[5] - snap);
    end
    n_cmp++;
    if (width_err[5] - werr !== 0 || period_err[5] - perr !== 0) begin
      n_bad++;
      $display("[TB] FAIL fwd_timing: width_err=%0d period_err=%0d required 0/0",
               width_err[5] - werr, period_err[5] - perr);
    end
  endtask

  task automatic test_reverse_move;
    int snap;
    bit ok;
    press(B_D);
    n_cmp++;
    if (lcd_num !== 4'd0) begin
      n_bad++;
      $display("[TB] FAIL tens_down: lcd=%0d required 0", lcd_num);
    end
    press(B_R);
    press(B_D);
    press(B_D);
    press(B_D);
    n_cmp++;
    if (num !== 2'd3 || lcd_num !== 4'd8) begin
      n_bad++;
      $display("[TB] FAIL units_wrap: num=%0d lcd=%0d required 3/8", num, lcd_num);
    end
    snap = rise_cnt[5];
    press(B_E);
    n_cmp++;
    if (dr[5] !== 1'b0 || mf[5] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL rev_start: dr=%b mf=%b required dr[5]=0 mf[5]=1", dr, mf);
    end
    wait_idle(5, 1000, ok);
    n_cmp++;
    if (!ok || rise_cnt[5] - snap !== 3) begin
      n_bad++;
      $display("[TB] FAIL rev_pulses: idle=%0d pulses=%0d required 1/3", ok, rise_cnt[5] - snap);
    end
  endtask

  task automatic test_cursor_wrap;
    int snap, others;
    bit ok;
    press(B_R);
    n_cmp++;
    if (num !== 2'd0 || lcd_num !== 4'd5) begin
      n_bad++;
      $display("[TB] FAIL cursor_wrap_r: num=%0d lcd=%0d required 0/5", num, lcd_num);
    end
    press(B_U);
    press(B_U);
    press(B_L);
    n_cmp++;
    if (num !== 2'd3 || lcd_num !== 4'd8) begin
      n_bad++;
      $display("[TB] FAIL cursor_wrap_l: num=%0d lcd=%0d required 3/8", num, lcd_num);
    end
    press(B_U);
    press(B_U);
    press(B_U);
    n_cmp++;
    if (lcd_num !== 4'd1) begin
      n_bad++;
      $display("[TB] FAIL units_up_wrap: lcd=%0d required 1", lcd_num);
    end
    press(B_L);
    press(B_U);
    snap   = rise_cnt[1];
    others = rise_cnt[0] + rise_cnt[2] + rise_cnt[3] + rise_cnt[4] + rise_cnt[5];
    press(B_E);
    n_cmp++;
    if (dr[1] !== 1'b1 || mf !== 6'b000010) begin
      n_bad++;
      $display("[TB] FAIL m1_start: dr=%b mf=%b required dr[1]=1 mf=000010", dr, mf);
    end
    wait_idle(1, 1000, ok);
    n_cmp++;
    if (!ok || rise_cnt[1] - snap !== 11) begin
      n_bad++;
      $display("[TB] FAIL m1_pulses: idle=%0d pulses=%0d required 1/11", ok, rise_cnt[1] - snap);
    end
    n_cmp++;
    if (rise_cnt[0] + rise_cnt[2] + rise_cnt[3] + rise_cnt[4] + rise_cnt[5] - others !== 0) begin
      n_bad++;
      $display("[TB] FAIL others_idle: extra pulses=%0d required 0",
               rise_cnt[0] + rise_cnt[2] + rise_cnt[3] + rise_cnt[4] + rise_cnt[5] - others);
    end
  endtask

  // E and U edges land together: only the commit happens. Motor 5 moves
  // from 8 to 11, which also confirms the position left by the reverse move.
  task automatic test_simultaneous;
    int snap;
    bit ok;
    press(B_L);
    press(B_L);
    press(B_D);
    press(B_D);
    n_cmp++;
    if (num !== 2'd0 || lcd_num !== 4'd5) begin
      n_bad++;
      $display("[TB] FAIL reselect_5: num=%0d lcd=%0d required 0/5", num, lcd_num);
    end
    snap = rise_cnt[5];
    press(B_E | B_U);
    n_cmp++;
    if (lcd_num !== 4'd5) begin
      n_bad++;
      $display("[TB] FAIL combo_sel: lcd=%0d required 5", lcd_num);
    end
    n_cmp++;
    if (dr[5] !== 1'b1 || mf[5] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL combo_commit: dr=%b mf=%b required dr[5]=1 mf[5]=1", dr, mf);
    end
    wait_idle(5, 1000, ok);
    n_cmp++;
    if (!ok || rise_cnt[5] - snap !== 3) begin
      n_bad++;
      $display("[TB] FAIL combo_pulses: idle=%0d pulses=%0d required 1/3", ok, rise_cnt[5] - snap);
    end
  endtask

  // A home switch during a homeward move halts the motor, zeroes its
  // position and clears its target.
  task automatic test_stop_safety;
    int snap;
    bit ok;
    press(B_L);
    press(B_U);
    press(B_U);
    press(B_U);
    press(B_U);
    press(B_L);
    press(B_D);
    n_cmp++;
    if (num !== 2'd2 || lcd_num !== 4'd0) begin
      n_bad++;
      $display("[TB] FAIL digits_005: num=%0d lcd=%0d required 2/0", num, lcd_num);
    end
    snap = rise_cnt[5];
    press(B_E);
    n_cmp++;
    if (dr[5] !== 1'b0 || mf[5] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL home_move: dr=%b mf=%b required dr[5]=0 mf[5]=1", dr, mf);
    end
    wait_rises(5, snap + 2, 200, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("[TB] FAIL home_move_timeout: pulses=%0d required 2", rise_cnt[5] - snap);
    end
    stop[5] = 1'b1;
    repeat (4) @(negedge sysclk);
    stop[5] = 1'b0;
    n_cmp++;
    if (mf[5] !== 1'b0 || pu[5] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL safety_halt: mf=%b pu=%b required bit5 0/0", mf, pu);
    end
    snap = rise_cnt[5];
    repeat (4 * SH + 4) @(negedge sysclk);
    n_cmp++;
    if (mf[5] !== 1'b0 || rise_cnt[5] !== snap) begin
      n_bad++;
      $display("[TB] FAIL safety_target_cleared: mf=%b new pulses=%0d required 0/0", mf, rise_cnt[5] - snap);
    end
    press(B_E);
    n_cmp++;
    if (dr[5] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL after_safety_dir: dr=%b required dr[5]=1", dr);
    end
    wait_idle(5, 1000, ok);
    n_cmp++;
    if (!ok || rise_cnt[5] - snap !== 5) begin
      n_bad++;
      $display("[TB] FAIL after_safety_pulses: idle=%0d pulses=%0d required 1/5", ok, rise_cnt[5] - snap);
    end
  endtask

  task automatic test_reset_midmove;
    int snap;
    bit ok;
    press(B_U);
    snap = rise_cnt[5];
    press(B_E);
    wait_rises(5, snap + 2, 200, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("[TB] FAIL mid_move_timeout: pulses=%0d required 2", rise_cnt[5] - snap);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pu, mf, dr, lcd_enable, num, lcd_num} !== 25'd0) begin
      n_bad++;
      $display("[TB] FAIL mid_reset: pu/mf/dr/en/num/lcd=%h required 0",
               {pu, mf, dr, lcd_enable, num, lcd_num});
    end
    @(negedge sysclk);
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);
    n_cmp++;
    if (mf !== 6'h3F || lcd_enable !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL rehoming: mf=%b en=%b required 111111/0", mf, lcd_enable);
    end
  endtask

  initial begin
    $display("[TB] ctrl_system directed bench, STEP_HALF=%0d", SH);
    test_reset;
    test_homing;
    test_select_wrap;
    test_forward_move;
    test_reverse_move;
    test_cursor_wrap;
    test_simultaneous;
    test_stop_safety;
    test_reset_midmove;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
